// File: rtl/sar_adc_seq.sv
// Multi-channel scan sequencer in front of a shared SAR ADC core.
// Optional 4x averaging per channel is built when SAR_SEQ_AVG_EN is defined.
module sar_adc_seq #(
    parameter int SIZE   = 8,
    parameter int NCH    = 6,
    parameter int SETTLE = 4,
    localparam int CW    = $clog2(NCH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NCH-1:0]      chan_mask,
    input  logic                cont,
    input  logic                trig,
    input  logic [NCH-1:0]      rd_clr,
    output logic                sar_start,
    input  logic                sar_done,
    input  logic [SIZE-1:0]     sar_out,
    output logic [CW-1:0]       chan_sel,
    output logic [NCH*SIZE-1:0] result,
    output logic [NCH-1:0]      result_valid,
    output logic                busy,
    output logic                scan_done,
    output logic                err,
    output logic [2:0]          state_dbg
);

    localparam int WD_LIM = 2 * SIZE + 4;
    localparam int WDW    = $clog2(WD_LIM);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_STORE  = 3'd4
    } state_t;

    state_t         state;
    logic [7:0]     settle_cnt;
    logic [WDW-1:0] wd_cnt;
    logic           chan_ok;
    logic           final_step;

`ifdef SAR_SEQ_AVG_EN
    logic [2:0]      samp;
    logic [SIZE+1:0] acc;
    assign final_step = (samp == 3'd4);
`else
    assign final_step = 1'b1;
`endif

    // Lowest set mask bit, and the next set bit above the current channel.
    logic [CW-1:0] first_ch;
    logic [CW-1:0] next_ch;
    logic          has_next;
    always_comb begin
        first_ch = '0;
        next_ch  = '0;
        has_next = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) first_ch = CW'(i);
            if (chan_mask[i] && (i > int'(chan_sel))) begin
                next_ch  = CW'(i);
                has_next = 1'b1;
            end
        end
    end

    assign scan_done = (state == ST_STORE) && enable && final_step && !has_next;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            chan_sel     <= '0;
            result       <= '0;
            result_valid <= '0;
            busy         <= 1'b0;
            sar_start    <= 1'b0;
            err          <= 1'b0;
            settle_cnt   <= '0;
            wd_cnt       <= '0;
            chan_ok      <= 1'b0;
`ifdef SAR_SEQ_AVG_EN
            samp         <= '0;
            acc          <= '0;
`endif
        end else begin
            sar_start    <= 1'b0;
            result_valid <= result_valid & ~rd_clr;
            if (!enable) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                if (state == ST_IDLE && trig) err <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (trig) err <= 1'b0;
                        if (trig && |chan_mask) begin
                            chan_sel   <= first_ch;
                            settle_cnt <= '0;
                            chan_ok    <= 1'b1;
                            busy       <= 1'b1;
                            state      <= ST_SETTLE;
`ifdef SAR_SEQ_AVG_EN
                            samp       <= '0;
                            acc        <= '0;
`endif
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_cnt == 8'(SETTLE - 1)) begin
                            sar_start <= 1'b1;
                            state     <= ST_START;
                        end else begin
                            settle_cnt <= settle_cnt + 8'd1;
                        end
                    end
                    ST_START: begin
                        wd_cnt <= '0;
                        state  <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (sar_done) begin
`ifdef SAR_SEQ_AVG_EN
                            acc <= acc + (SIZE + 2)'(sar_out);
`else
                            result[int'(chan_sel)*SIZE +: SIZE] <= sar_out;
`endif
                            state <= ST_STORE;
                        end else if (wd_cnt == WDW'(WD_LIM - 1)) begin
                            // Missing done: flag it and drop this channel's result.
                            err     <= 1'b1;
                            chan_ok <= 1'b0;
                            state   <= ST_STORE;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
                    end
                    ST_STORE: begin
`ifdef SAR_SEQ_AVG_EN
                        if (samp < 3'd3) begin
                            samp      <= samp + 3'd1;
                            sar_start <= 1'b1;
                            state     <= ST_START;
                        end else if (samp == 3'd3) begin
                            samp <= 3'd4;
                            if (chan_ok) result[int'(chan_sel)*SIZE +: SIZE] <= acc[SIZE+1:2];
                        end else begin
`else
                        begin
`endif
                            if (chan_ok) result_valid[chan_sel] <= 1'b1;
                            if (has_next || (cont && |chan_mask)) begin
                                chan_sel   <= has_next ? next_ch : first_ch;
                                settle_cnt <= '0;
                                chan_ok    <= 1'b1;
                                state      <= ST_SETTLE;
`ifdef SAR_SEQ_AVG_EN
                                samp       <= '0;
                                acc        <= '0;
`endif
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sar_adc_seq.md
# sar_adc_seq

Multi-channel scan sequencer for the shared 8-bit SAR ADC core. It drives the analog input mux, waits a programmable settling time, pulses the SAR start, and captures each conversion result into a per-channel result register. It sits between the SAR core and the register/bus interface, so software sees NCH independent ADC channels while only one SAR/DAC/comparator exists.

## Interface
- SIZE, 8: SAR result width.
- NCH, 6: number of analog channels (2..16); CW = $clog2(NCH).
- SETTLE, 4: mux settling cycles before each start (1..255).
- clk  in  1  clock, also clocks the SAR core.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  sequencer enable; low aborts any scan.
- chan_mask  in  NCH  channels included in a scan.
- cont  in  1  0 = single scan per trig, 1 = continuous scanning.
- trig  in  1  scan request, sampled in IDLE only.
- rd_clr  in  NCH  per-channel clear of result_valid (read acknowledge).
- sar_start  out  1  one-cycle start pulse to the SAR.
- sar_done  in  1  SAR done (one cycle).
- sar_out  in  SIZE  SAR result, valid only while sar_done=1.
- chan_sel  out  CW  analog mux select.
- result  out  NCH*SIZE  channel n at [n*SIZE +: SIZE].
- result_valid  out  NCH  sticky: new result since last rd_clr.
- busy  out  1  high in any state except IDLE.
- scan_done  out  1  one-cycle pulse after last enabled channel stored.
- err  out  1  sticky watchdog error; cleared by trig in IDLE.

## Operation
- States: IDLE, SETTLE, START, WAIT, STORE.
- IDLE: if enable & trig & |chan_mask -> load chan_sel with lowest set mask bit, clear settle counter, go SETTLE. trig with chan_mask=0 is ignored.
- SETTLE: count SETTLE cycles, then START.
- START: sar_start=1 for exactly one cycle -> WAIT.
- WAIT: on sar_done=1 capture sar_out into result[chan_sel] (same edge) -> STORE. Watchdog: if sar_done is not seen within 2*SIZE+4 cycles of entering WAIT, set err, leave the result unchanged, and go to STORE.
- STORE: set result_valid[chan_sel] (if captured). Next channel = next higher set bit of chan_mask, sampled now. If one exists -> SETTLE with the new chan_sel. Otherwise pulse scan_done; then cont=1 & enable -> wrap to lowest set bit -> SETTLE, else -> IDLE.
- chan_mask changes take effect only at STORE; a channel being converted is always completed.
- enable low in any state: next edge -> IDLE, no capture, no scan_done, and sar_start is never issued. An in-flight SAR conversion completes harmlessly; sar_done arriving in IDLE is ignored.
- rd_clr[n] clears result_valid[n]; a simultaneous set in STORE for n wins (valid stays 1).
- Reset values: state IDLE, chan_sel 0, result all 0, result_valid 0, busy 0, sar_start 0, scan_done 0, err 0.

## Timing
- sar_start is registered, and SAR sees it in its IDLE state. The SAR asserts done SIZE+1 cycles after the edge sampling start (9 for SIZE=8).
- Per-channel latency (first SETTLE cycle to STORE) = SETTLE + 1 + (SIZE+1) + 1 cycles; 15 for defaults.
- chan_sel is stable from SETTLE entry through STORE of that channel.
- busy rises the edge after trig is sampled; scan_done coincides with the final STORE cycle.

## Configuration
- SAR_SEQ_AVG_EN defined: each channel is converted 4 times back-to-back (SETTLE only before the first). The unsigned SIZE+2-bit sum is accumulated, and result = sum >> 2 (truncating). A watchdog in any of the 4 conversions discards the whole channel. Per-channel latency becomes SETTLE + 4*(SIZE+3) + 1.
- Undefined: a single conversion per channel, with no accumulator logic.

## Test plan
- Reset mid-scan (reset_n low in WAIT) -> all outputs at reset values next cycle; a sar_done arriving after release is ignored.
- chan_mask=6'b100101, cont=0, trig; SAR model returns 8'h10+ch -> channels 0,2,5 converted in order, result[0]=8'h10, result[2]=8'h12, result[5]=8'h15, result_valid=6'b100101, one scan_done, 15 cycles per channel.
- cont=1, chan_mask=6'b000010 -> chan_sel stays 1, scan_done every 15 cycles; enable dropped in SETTLE -> IDLE next edge with no sar_start.
- SAR model never returns done -> err=1 after 20 WAIT cycles, result unchanged, scan proceeds to the next channel; trig in IDLE clears err.
- rd_clr[2] in the same cycle as STORE of channel 2 -> result_valid[2] remains 1; rd_clr alone -> cleared.
- SAR_SEQ_AVG_EN with samples 8'h10,8'h11,8'h12,8'h13 -> result 8'h11.
